// File: rtl/dcache_qspi_pkg.sv
// Shared types and constants for the data-cache QSPI line sequencer.
package dcache_qspi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      RDATA,
      WDATA,
      GAP
   } state_t;

   localparam logic [7:0] CMD_READ_DEFAULT  = 8'hEB;
   localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h38;

   localparam int CMD_NIBBLES  = 2;
   localparam int ADDR_NIBBLES = 6;

   // One nibble counter serves every state; 4 bits covers the longest phase.
   localparam int CNT_W = 4;

endpackage

// File: rtl/dcache_qspi.sv
// Line-transfer sequencer between the data cache and a 4-bit QSPI PSRAM.
// Writebacks stream the line out of the cache, fills stream it back in,
// and busy holds the pipeline for the whole transaction.
module dcache_qspi
   import dcache_qspi_pkg::*;
#(
   parameter int          PA          = 22,
   parameter int          LINE_LENGTH = 4,
   parameter int          READ_DUMMY  = 6,
   parameter int          CS_HIGH     = 1,
   parameter logic [7:0]  CMD_READ    = CMD_READ_DEFAULT,
   parameter logic [7:0]  CMD_WRITE   = CMD_WRITE_DEFAULT
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                req,
   input  logic                                fault,
   input  logic                                push,
   input  logic                                pull,
   input  logic [PA-$clog2(LINE_LENGTH)-1:0]   tag,
   input  logic [3:0]                          dwrite,
   output logic [3:0]                          dread,
   output logic                                wstrobe_d,
   output logic                                rstrobe_d,
   output logic                                busy,
   output logic                                qspi_cs_n,
   output logic                                qspi_sclk_en,
   output logic [3:0]                          qspi_io_out,
   output logic                                qspi_io_oe,
   input  logic [3:0]                          qspi_io_in
);

   localparam int OFF_W   = $clog2(LINE_LENGTH);
   localparam int TAG_W   = PA - OFF_W;
   localparam int NIBBLES = 2 * LINE_LENGTH;

   state_t             state;
   state_t             next;
   logic [CNT_W-1:0]   cnt;
   logic [TAG_W-1:0]   tag_q;
   logic               write_op;
   logic [3:0]         io_in_q;
   logic               accept;
   logic               last;
   int                 len;
   logic [7:0]         opcode;
   logic [23:0]        addr;
   logic [23:0]        addr_shift;

   // A new transaction starts only from IDLE; push wins over pull.
   assign accept = (state == IDLE) && req && !fault && (push || pull) && !reset;

   assign opcode     = write_op ? CMD_WRITE : CMD_READ;
   assign addr       = 24'({tag_q, {OFF_W{1'b0}}});
   assign addr_shift = addr << {cnt, 2'b00};

   assign busy  = (state != IDLE) || accept;
   assign dread = io_in_q;

   // Length of the current phase; RDATA runs one extra cycle so the
   // registered read data can drain while cs_n is still low.
   always_comb begin
      len = 1;
      case (state)
         CMD:     len = CMD_NIBBLES;
         ADDR:    len = ADDR_NIBBLES;
         DUMMY:   len = READ_DUMMY;
         RDATA:   len = NIBBLES + 1;
         WDATA:   len = NIBBLES;
         GAP:     len = CS_HIGH;
         default: len = 1;
      endcase
      last = (int'(cnt) == len - 1);
   end

   // State register and per-phase nibble counter, reloaded on every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next;
         if ((next != state) || (next == IDLE))
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Transaction parameters are captured at acceptance; the pad input is
   // registered unconditionally so read data lands one cycle after its SCLK.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q    <= '0;
         write_op <= 1'b0;
         io_in_q  <= '0;
      end else begin
         io_in_q <= qspi_io_in;
         if (accept) begin
            tag_q    <= tag;
            write_op <= push;
         end
      end
   end

   // Phase sequencing; inputs other than reset are ignored once running.
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (accept) next = CMD;
         CMD:     if (last) next = ADDR;
         ADDR:    if (last) next = write_op ? WDATA : ((READ_DUMMY > 0) ? DUMMY : RDATA);
         DUMMY:   if (last) next = RDATA;
         RDATA:   if (last) next = GAP;
         WDATA:   if (last) next = GAP;
         GAP:     if (last) next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Bus and cache strobe outputs decoded from the phase and nibble count.
   always_comb begin
      qspi_cs_n    = 1'b1;
      qspi_sclk_en = 1'b0;
      qspi_io_oe   = 1'b0;
      qspi_io_out  = 4'h0;
      wstrobe_d    = 1'b0;
      rstrobe_d    = 1'b0;
      case (state)
         CMD: begin
            qspi_cs_n    = 1'b0;
            qspi_sclk_en = 1'b1;
            qspi_io_oe   = 1'b1;
            qspi_io_out  = cnt[0] ? opcode[3:0] : opcode[7:4];
         end
         ADDR: begin
            qspi_cs_n    = 1'b0;
            qspi_sclk_en = 1'b1;
            qspi_io_oe   = 1'b1;
            qspi_io_out  = addr_shift[23:20];
         end
         DUMMY: begin
            qspi_cs_n    = 1'b0;
            qspi_sclk_en = 1'b1;
         end
         RDATA: begin
            qspi_cs_n    = 1'b0;
            qspi_sclk_en = (int'(cnt) < NIBBLES);
            wstrobe_d    = (cnt != '0);
         end
         WDATA: begin
            qspi_cs_n    = 1'b0;
            qspi_sclk_en = 1'b1;
            qspi_io_oe   = 1'b1;
            qspi_io_out  = dwrite;
            rstrobe_d    = 1'b1;
         end
         default: begin
            qspi_cs_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_qspi.sv
// Directed bench for dcache_qspi: a default build and a READ_DUMMY=4 build
// share one set of inputs and are checked cycle by cycle against
// hand-derived timelines relative to C, the first cycle with cs_n low.
module tb_dcache_qspi;

   logic        clk;
   logic        reset;
   logic        req;
   logic        fault;
   logic        push;
   logic        pull;
   logic [19:0] tag;
   logic [3:0]  dwrite;
   logic [3:0]  qspi_io_in;

   logic [3:0]  dread,  dread_4;
   logic        wstrobe_d, wstrobe_d_4;
   logic        rstrobe_d, rstrobe_d_4;
   logic        busy, busy_4;
   logic        qspi_cs_n, qspi_cs_n_4;
   logic        qspi_sclk_en, qspi_sclk_en_4;
   logic [3:0]  qspi_io_out, qspi_io_out_4;
   logic        qspi_io_oe, qspi_io_oe_4;

   int tests;
   int failures;

   dcache_qspi dut (
      .clk(clk), .reset(reset), .req(req), .fault(fault), .push(push), .pull(pull),
      .tag(tag), .dwrite(dwrite), .dread(dread), .wstrobe_d(wstrobe_d),
      .rstrobe_d(rstrobe_d), .busy(busy), .qspi_cs_n(qspi_cs_n),
      .qspi_sclk_en(qspi_sclk_en), .qspi_io_out(qspi_io_out),
      .qspi_io_oe(qspi_io_oe), .qspi_io_in(qspi_io_in)
   );

   dcache_qspi #(.READ_DUMMY(4)) dut4 (
      .clk(clk), .reset(reset), .req(req), .fault(fault), .push(push), .pull(pull),
      .tag(tag), .dwrite(dwrite), .dread(dread_4), .wstrobe_d(wstrobe_d_4),
      .rstrobe_d(rstrobe_d_4), .busy(busy_4), .qspi_cs_n(qspi_cs_n_4),
      .qspi_sclk_en(qspi_sclk_en_4), .qspi_io_out(qspi_io_out_4),
      .qspi_io_oe(qspi_io_oe_4), .qspi_io_in(qspi_io_in)
   );

   // 10 ns free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs for a cycle are applied 1 ns after the rising edge and outputs
   // are sampled 1 ns later, well clear of the next edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b1; push = 1'b1; pull = 1'b1; fault = 1'b0;
      tag = 20'h0; dwrite = 4'h0; qspi_io_in = 4'h0;
      next_cycle();
      next_cycle();
      #1;
      tests++;
      if ({qspi_cs_n, qspi_sclk_en, qspi_io_oe, qspi_io_out, wstrobe_d, rstrobe_d, busy} !== 10'b1_0_0_0000_0_0_0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got %b exp %b",
                  {qspi_cs_n, qspi_sclk_en, qspi_io_oe, qspi_io_out, wstrobe_d, rstrobe_d, busy}, 10'b1_0_0_0000_0_0_0);
      end
      tests++;
      if ({qspi_cs_n_4, wstrobe_d_4, rstrobe_d_4, busy_4} !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL reset_outputs_rd4 got %b exp %b",
                  {qspi_cs_n_4, wstrobe_d_4, rstrobe_d_4, busy_4}, 4'b1000);
      end
      next_cycle();
      reset = 1'b0; req = 1'b0; push = 1'b0; pull = 1'b0;
   endtask

   // Fill of tag 12345. The pad stream is v[t] = (t+12) mod 16, so the
   // default build samples A,B,...,F,0,1 at C+14..C+21 and the READ_DUMMY=4
   // build samples 8..F at C+12..C+19; both present v[t-1] on dread.
   // A non-negative reset_at asserts reset during that cycle and checks
   // the idle state one cycle later.
   task automatic test_pull(input int reset_at);
      logic [3:0] addr_nib [6];
      logic [4:0] got_ctl, exp_ctl;
      addr_nib = '{4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
      next_cycle();
      req = 1'b1; pull = 1'b1; push = 1'b0; fault = 1'b0; tag = 20'h12345;
      #1;
      tests++;
      if ({busy, qspi_cs_n, busy_4} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL pull_accept got %b exp %b", {busy, qspi_cs_n, busy_4}, 3'b111);
      end
      for (int t = 0; t <= 26; t++) begin
         next_cycle();
         req = 1'b0; pull = 1'b0;
         qspi_io_in = 4'(t + 12);
         reset = (t == reset_at);
         #1;
         if (reset_at >= 0 && t == reset_at + 1) begin
            tests++;
            if ({qspi_cs_n, busy, wstrobe_d, qspi_sclk_en, qspi_io_oe} !== 5'b10000) begin
               failures++;
               $display("[TB] FAIL reset_mid t=%0d got %b exp %b", t,
                        {qspi_cs_n, busy, wstrobe_d, qspi_sclk_en, qspi_io_oe}, 5'b10000);
            end
            tests++;
            if ({qspi_cs_n_4, busy_4, wstrobe_d_4} !== 3'b100) begin
               failures++;
               $display("[TB] FAIL reset_mid_rd4 t=%0d got %b exp %b", t,
                        {qspi_cs_n_4, busy_4, wstrobe_d_4}, 3'b100);
            end
            break;
         end
         got_ctl = {qspi_cs_n, busy, wstrobe_d, qspi_sclk_en, qspi_io_oe};
         exp_ctl = {(t > 22), (t <= 23), (t >= 15 && t <= 22), (t <= 21), (t <= 7)};
         tests++;
         if (got_ctl !== exp_ctl) begin
            failures++;
            $display("[TB] FAIL pull_ctl t=%0d got %b exp %b (cs_n,busy,wstrobe,sclk,oe)", t, got_ctl, exp_ctl);
         end
         got_ctl = {qspi_cs_n_4, busy_4, wstrobe_d_4, qspi_sclk_en_4, qspi_io_oe_4};
         exp_ctl = {(t > 20), (t <= 21), (t >= 13 && t <= 20), (t <= 19), (t <= 7)};
         tests++;
         if (got_ctl !== exp_ctl) begin
            failures++;
            $display("[TB] FAIL pull_ctl_rd4 t=%0d got %b exp %b (cs_n,busy,wstrobe,sclk,oe)", t, got_ctl, exp_ctl);
         end
         if (t <= 7) begin
            tests++;
            if (qspi_io_out !== ((t == 0) ? 4'hE : (t == 1) ? 4'hB : addr_nib[(t < 2) ? 0 : t - 2])) begin
               failures++;
               $display("[TB] FAIL pull_io_out t=%0d got %h exp %h", t, qspi_io_out,
                        (t == 0) ? 4'hE : (t == 1) ? 4'hB : addr_nib[(t < 2) ? 0 : t - 2]);
            end
         end
         if (t >= 15 && t <= 22) begin
            tests++;
            if (dread !== 4'(t + 11)) begin
               failures++;
               $display("[TB] FAIL pull_dread t=%0d got %h exp %h", t, dread, 4'(t + 11));
            end
         end
         if (t >= 13 && t <= 20) begin
            tests++;
            if (dread_4 !== 4'(t + 11)) begin
               failures++;
               $display("[TB] FAIL pull_dread_rd4 t=%0d got %h exp %h", t, dread_4, 4'(t + 11));
            end
         end
      end
      reset = 1'b0;
   endtask

   // Writeback of tag ABCDE (byte address 2AF378); the cache supplies
   // 5,6,...,C at C+8..C+15, i.e. dwrite = (t-3) mod 16.
   task automatic test_push();
      logic [3:0] addr_nib [6];
      logic [3:0] exp_io;
      logic [5:0] got_ctl, exp_ctl;
      addr_nib = '{4'h2, 4'hA, 4'hF, 4'h3, 4'h7, 4'h8};
      next_cycle();
      req = 1'b1; push = 1'b1; pull = 1'b0; fault = 1'b0; tag = 20'hABCDE;
      #1;
      for (int t = 0; t <= 20; t++) begin
         next_cycle();
         req = 1'b0; push = 1'b0;
         dwrite = 4'(t - 3);
         qspi_io_in = 4'(t);
         #1;
         exp_ctl = {(t > 15), (t <= 16), (t >= 8 && t <= 15), 1'b0, (t <= 15), (t <= 15)};
         got_ctl = {qspi_cs_n, busy, rstrobe_d, wstrobe_d, qspi_sclk_en, qspi_io_oe};
         tests++;
         if (got_ctl !== exp_ctl) begin
            failures++;
            $display("[TB] FAIL push_ctl t=%0d got %b exp %b (cs_n,busy,rstrobe,wstrobe,sclk,oe)", t, got_ctl, exp_ctl);
         end
         got_ctl = {qspi_cs_n_4, busy_4, rstrobe_d_4, wstrobe_d_4, qspi_sclk_en_4, qspi_io_oe_4};
         tests++;
         if (got_ctl !== exp_ctl) begin
            failures++;
            $display("[TB] FAIL push_ctl_rd4 t=%0d got %b exp %b (cs_n,busy,rstrobe,wstrobe,sclk,oe)", t, got_ctl, exp_ctl);
         end
         if (t <= 15) begin
            if (t == 0)      exp_io = 4'h3;
            else if (t == 1) exp_io = 4'h8;
            else if (t <= 7) exp_io = addr_nib[t - 2];
            else             exp_io = 4'(t - 3);
            tests++;
            if (qspi_io_out !== exp_io) begin
               failures++;
               $display("[TB] FAIL push_io_out t=%0d got %h exp %h", t, qspi_io_out, exp_io);
            end
         end
      end
   endtask

   // Dirty miss: push and pull together. The write runs first; the cache
   // drops push after acceptance, so the next IDLE cycle accepts the fill.
   task automatic test_push_pull();
      int rs_count, ws_count, ws4_count;
      rs_count = 0; ws_count = 0; ws4_count = 0;
      next_cycle();
      req = 1'b1; push = 1'b1; pull = 1'b1; fault = 1'b0; tag = 20'h00F0F;
      #1;
      for (int t = 0; t <= 44; t++) begin
         next_cycle();
         push = 1'b0;
         req  = (t <= 17);
         pull = (t <= 17);
         dwrite = 4'(t);
         qspi_io_in = 4'(~t);
         #1;
         if (rstrobe_d)   rs_count++;
         if (wstrobe_d)   ws_count++;
         if (wstrobe_d_4) ws4_count++;
         if (t == 0) begin
            tests++;
            if (qspi_io_out !== 4'h3) begin
               failures++;
               $display("[TB] FAIL both_first_opcode got %h exp %h", qspi_io_out, 4'h3);
            end
         end
         if (t == 16 || t == 17) begin
            tests++;
            if ({qspi_cs_n, busy} !== 2'b11) begin
               failures++;
               $display("[TB] FAIL both_gap t=%0d got %b exp %b (cs_n,busy)", t, {qspi_cs_n, busy}, 2'b11);
            end
         end
         if (t == 18) begin
            tests++;
            if ({qspi_cs_n, qspi_io_out} !== 5'b0_1110) begin
               failures++;
               $display("[TB] FAIL both_second_start got %b exp %b (cs_n,io_out)", {qspi_cs_n, qspi_io_out}, 5'b0_1110);
            end
         end
         if (t == 17) begin
            tests++;
            if (rs_count !== 8) begin
               failures++;
               $display("[TB] FAIL both_write_strobes got %0d exp %0d", rs_count, 8);
            end
         end
      end
      tests++;
      if (ws_count !== 8) begin
         failures++;
         $display("[TB] FAIL both_read_strobes got %0d exp %0d", ws_count, 8);
      end
      tests++;
      if (ws4_count !== 8) begin
         failures++;
         $display("[TB] FAIL both_read_strobes_rd4 got %0d exp %0d", ws4_count, 8);
      end
      tests++;
      if ({qspi_cs_n, busy, rs_count} !== {1'b1, 1'b0, 32'd8}) begin
         failures++;
         $display("[TB] FAIL both_end got cs_n=%b busy=%b rstrobes=%0d exp cs_n=1 busy=0 rstrobes=8",
                  qspi_cs_n, busy, rs_count);
      end
   endtask

   // A faulting access must never start a transaction.
   task automatic test_fault();
      for (int t = 0; t < 5; t++) begin
         next_cycle();
         req = 1'b1; fault = 1'b1; push = 1'b1; pull = (t[0] == 1'b1);
         #1;
         tests++;
         if ({qspi_cs_n, busy} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL fault_block t=%0d got %b exp %b (cs_n,busy)", t, {qspi_cs_n, busy}, 2'b10);
         end
      end
      next_cycle();
      req = 1'b0; fault = 1'b0; push = 1'b0; pull = 1'b0;
      #1;
      tests++;
      if ({qspi_cs_n, busy, qspi_cs_n_4} !== 3'b101) begin
         failures++;
         $display("[TB] FAIL fault_after got %b exp %b", {qspi_cs_n, busy, qspi_cs_n_4}, 3'b101);
      end
   endtask

   initial begin
      tests = 0;
      failures = 0;
      test_reset();
      test_pull(-1);
      test_push();
      test_push_pull();
      test_fault();
      test_pull(18);
      test_pull(-1);
      next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/dcache_qspi.md
Name: dcache_qspi

Overview:
- Line-transfer sequencer directly downstream of the data cache; services the cache's push (writeback) and pull (fill) requests over a 4-bit QSPI/QPI PSRAM bus.
- Issues command, address and dummy nibbles, then exactly 2*LINE_LENGTH back-to-back nibble strobes into the cache (wstrobe_d/dread) or out of it (rstrobe_d/dwrite).
- Asserts busy so the pipeline holds paddr stable for the whole transfer.

Parameters:
- PA, 22: physical address width (halfword-addressed bus, byte address PA bits).
- LINE_LENGTH, 4: cache line bytes; the transfer is 2*LINE_LENGTH nibbles.
- READ_DUMMY, 6: dummy nibble cycles between address and read data.
- CS_HIGH, 1: minimum cycles with cs_n high between transactions.
- CMD_READ, 8'hEB: quad read opcode.
- CMD_WRITE, 8'h38: quad write opcode.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  a memory-stage load or store is active this cycle.
- fault  in  1  MMU fault on the current access; blocks acceptance.
- push  in  1  cache needs a writeback of the indexed line.
- pull  in  1  cache needs a fill of the indexed line.
- tag  in  PA-$clog2(LINE_LENGTH)  line address from the cache.
- dwrite  in  4  nibble from the cache, valid during rstrobe_d.
- dread  out  4  nibble to the cache, valid during wstrobe_d.
- wstrobe_d  out  1  write dread into the cache line.
- rstrobe_d  out  1  the cache nibble is consumed this cycle.
- busy  out  1  transaction in progress; the pipeline must stall.
- qspi_cs_n  out  1  chip select, active low.
- qspi_sclk_en  out  1  pad ring gates one SCLK pulse this cycle.
- qspi_io_out  out  4  output nibble.
- qspi_io_oe  out  1  output enable for io_out.
- qspi_io_in  in  4  input nibble, registered internally every cycle.

Behaviour:
- Reset, including mid-transaction: state IDLE; cs_n=1, sclk_en=0, io_oe=0, io_out=0, wstrobe_d=0, rstrobe_d=0, busy=0, counters=0. No partial strobe burst continues after reset.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP.
- IDLE: accept when req && !fault && (push||pull).
  - Latch tag and op; push has priority (write), otherwise read.
  - busy=1 from the acceptance cycle until GAP exits.
- Cycle numbering: C = first cycle with cs_n=0.
- CMD, 2 cycles: io_oe=1, sclk_en=1, opcode sent high nibble first.
- ADDR, 6 cycles: 24-bit byte address {zero-pad, tag, $clog2(LINE_LENGTH) zeros}, MSB nibble first.
- Write path: ADDR goes to WDATA.
  - WDATA: 2*LINE_LENGTH consecutive cycles (C+8..C+15 at default); rstrobe_d=1, io_out=dwrite (same-cycle combinational pass-through), io_oe=1, sclk_en=1.
- Read path: ADDR goes to DUMMY.
  - DUMMY: READ_DUMMY cycles with io_oe=0, sclk_en=1.
  - RDATA: sclk_en=1 for 2*LINE_LENGTH sampling cycles. Each sampled nibble is presented on dread with wstrobe_d=1 one cycle later.
  - This gives 2*LINE_LENGTH contiguous wstrobe_d cycles (C+15..C+22 at default), with cs_n held low through the last strobe.
- Strobe contiguity: strobes are never gapped inside a burst, because the cache's nibble offset resets on any gap. Nibble order is high nibble of byte 0 first.
- GAP: cs_n=1 for CS_HIGH cycles, then IDLE with busy=0.
- Back-to-back transactions: a dirty miss yields a push transaction, then (cache now clean) a pull transaction. The second is accepted no earlier than the cycle after GAP ends.
- Inputs ignored while not in IDLE: fault, push, pull and req changes mid-transaction. Only reset aborts.
- Counters: a single 4-bit nibble counter, reloaded per state, must hold max(8, READ_DUMMY, 2*LINE_LENGTH+1).

Decomposition:
- Shared package dcache_qspi_pkg: state enum, CMD_READ/CMD_WRITE defaults, ADDR_NIBBLES=6 constant.
- No sub-module; address/command nibble mux and counter stay inline.

Test Plan:
- Pull, tag=20'h12345, memory returns nibbles A,B,C,D,E,F,0,1 -> opcode nibbles E,B; address nibbles 0,4,8,D,1,4; wstrobe_d high C+15..C+22; dread=A..1 in order; busy low after GAP.
- Push, dwrite stream 5,6,7,8,9,A,B,C -> opcode 3,8; rstrobe_d high exactly C+8..C+15; io_out matches dwrite each cycle; io_oe=1 throughout; cs_n high at C+16.
- Push and pull both high -> write transaction first; pull accepted after cs_n high ≥ CS_HIGH cycles; exactly 8 strobes per transaction.
- req with fault=1 and push=1 -> no acceptance; cs_n stays 1; busy=0.
- Reset at C+18 during RDATA -> next cycle cs_n=1, wstrobe_d=0, busy=0; new pull restarts from CMD.
- READ_DUMMY=4 build -> first wstrobe_d at C+13; still 8 contiguous strobes.
